timer_disp_scan: RTL

Display-side consumer of the countdown timer's hour/minute/second/digit-select outputs. Converts the three 6-bit binary fields to BCD with a serial double-dabble engine, double-buffers the result, and time-multiplexes six active-low seven-segment digits (HH.MM.SS). While the timer is in edit mode, the digit selected by the timer's digit pointer blinks. Sits between the timer and the board's seven-segment pins, on the same 1 kHz clock.

---
 rtl/timer_pkg.sv | 32 +++
 rtl/timer_bcd_serial.sv | 44 ++++
 rtl/timer_disp_scan.sv | 139 +++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: shared constants for the timer display path.
// Holds the digit count, separator positions, digit-pointer encodings,
// converter FSM state codes and the 16-entry seven-segment glyph table
// (active-low {g,f,e,d,c,b,a}; codes above 9 render blank).
package timer_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [2:0] SEP_POS_HH = 3'd1;
    localparam logic [2:0] SEP_POS_MM = 3'd3;

    localparam logic [2:0] DIGITP_HOUR_TENS = 3'd0;
    localparam logic [2:0] DIGITP_SEC_ONES  = 3'd5;
    localparam logic [2:0] DIGITP_NONE      = 3'd6;

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_STORE  = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [15:0][6:0] GLYPHS = {
        7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F,
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] glyph(input logic [3:0] n);
        return GLYPHS[n];
    endfunction

endpackage

// File: rtl/timer_bcd_serial.sv
// timer_bcd_serial: serial double-dabble converter, 6-bit binary to 2-digit BCD.
// Ports:
//   clk_i, reset_i  clock, synchronous active-high reset
//   start_i         load bin_i, clear the accumulator, begin six shift cycles
//   bin_i[5:0]      binary value sampled on start_i
//   busy_o          high while further shift cycles follow the current one
//   bcd_o[7:0]      {tens, ones}; valid the cycle after the sixth shift
module timer_bcd_serial (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [5:0] bin_i,
    output logic       busy_o,
    output logic [7:0] bcd_o
);
    logic [5:0] bin_q, bin_d;
    logic [7:0] acc_q, acc_d, adj;
    logic [2:0] cnt_q, cnt_d;

    assign adj[3:0] = acc_q[3:0] >= 4'd5 ? acc_q[3:0] + 4'd3 : acc_q[3:0];
    assign adj[7:4] = acc_q[7:4] >= 4'd5 ? acc_q[7:4] + 4'd3 : acc_q[7:4];

    always_comb begin
        bin_d = start_i ? bin_i : cnt_q != 3'd0 ? {bin_q[4:0], 1'b0} : bin_q;
        acc_d = start_i ? 8'd0 : cnt_q != 3'd0 ? {adj[6:0], bin_q[5]} : acc_q;
        cnt_d = start_i ? 3'd6 : cnt_q != 3'd0 ? cnt_q - 3'd1 : cnt_q;
    end

    // Drops on the final shift so the sequencer steps straight into STORE.
    assign busy_o = cnt_q > 3'd1;
    assign bcd_o  = acc_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            bin_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            bin_q <= bin_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/timer_disp_scan.sv
// timer_disp_scan: converts hour/min/sec to BCD and scans six active-low
// seven-segment digits (HH.MM.SS), marking the edit digit.
// Ports:
//   clk_i, reset_i        1 kHz clock, synchronous active-high reset
//   hour_i, min_i, sec_i  6-bit binary fields, shown as two decimal digits each
//   digitp_i[2:0]         edit digit 0..5 (hour tens .. sec ones), 6/7 none
//   edit_i                timer stopped and editable
//   an_o[5:0]             active-low anodes, bit k = position k (0 leftmost)
//   seg_o[6:0]            active-low cathodes {g,f,e,d,c,b,a}
//   dp_o                  active-low decimal point
// Parameters: SCAN_DIV cycles per digit (1..255), BLINK_HALF blink half-period.
// Build option TIMER_DISP_BLINK_EN: blank the edit digit on alternate
// half-periods; otherwise mark it by driving its decimal point low.
module timer_disp_scan
    import timer_pkg::*;
#(
    parameter int SCAN_DIV   = 1,
    parameter int BLINK_HALF = 250
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [5:0] hour_i,
    input  logic [5:0] min_i,
    input  logic [5:0] sec_i,
    input  logic [2:0] digitp_i,
    input  logic       edit_i,
    output logic [5:0] an_o,
    output logic [6:0] seg_o,
    output logic       dp_o
);
    localparam logic [7:0] SCAN_LAST = 8'(SCAN_DIV - 1);

    logic [1:0]       state_q, state_d, field_q, field_d;
    logic [5:0]       snap_min_q, snap_min_d, snap_sec_q, snap_sec_d;
    logic [0:2][7:0]  shadow_q, shadow_d;
    logic [0:5][3:0]  disp_q, disp_d;
    logic [7:0]       div_q, div_d;
    logic [2:0]       pos_q, pos_d;
    logic [5:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             start, busy, hide, mark, scan_last;
    logic [5:0]       bin;
    logic [7:0]       bcd;

    // hour_i goes straight into the converter at LOAD; its input register
    // is the hour snapshot, so only min/sec need private copies here.
    assign start = state_q == ST_LOAD || (state_q == ST_STORE && field_q != 2'd2);
    assign bin   = state_q == ST_LOAD ? hour_i : field_q == 2'd0 ? snap_min_q : snap_sec_q;

    timer_bcd_serial u_bcd (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .start_i (start),
        .bin_i   (bin),
        .busy_o  (busy),
        .bcd_o   (bcd)
    );

    always_comb begin
        state_d = state_q == ST_LOAD  ? ST_SHIFT :
                  state_q == ST_SHIFT ? (busy ? ST_SHIFT : ST_STORE) :
                  state_q == ST_STORE ? (field_q == 2'd2 ? ST_COMMIT : ST_SHIFT) : ST_LOAD;
        field_d = state_q == ST_LOAD ? 2'd0 : state_q == ST_STORE ? field_q + 2'd1 : field_q;
        snap_min_d = state_q == ST_LOAD ? min_i : snap_min_q;
        snap_sec_d = state_q == ST_LOAD ? sec_i : snap_sec_q;
        shadow_d = shadow_q;
        if (state_q == ST_STORE) shadow_d[field_q] = bcd;
        disp_d = state_q == ST_COMMIT ? shadow_q : disp_q;
    end

    assign scan_last = div_q == SCAN_LAST;
    assign div_d     = scan_last ? 8'd0 : div_q + 8'd1;
    assign pos_d     = !scan_last ? pos_q : pos_q == 3'd5 ? 3'd0 : pos_q + 3'd1;

`ifdef TIMER_DISP_BLINK_EN
    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;

    assign blink_cnt_d = !edit_i || blink_cnt_q == BLINK_LAST ? '0 : blink_cnt_q + 1'b1;
    assign phase_d     = !edit_i ? 1'b1 : blink_cnt_q == BLINK_LAST ? !phase_q : phase_q;
    assign hide        = edit_i && !phase_q && digitp_i == pos_q;
    assign mark        = 1'b0;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end
`else
    localparam int unused_blink_half = BLINK_HALF;

    assign hide = 1'b0;
    assign mark = edit_i && digitp_i == pos_q;
`endif

    assign an_d  = ~(6'd1 << pos_q);
    assign seg_d = hide ? SEG_BLANK : glyph(disp_q[pos_q]);
    assign dp_d  = !(pos_q == SEP_POS_HH || pos_q == SEP_POS_MM || mark);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_LOAD;
            field_q    <= '0;
            snap_min_q <= '0;
            snap_sec_q <= '0;
            shadow_q   <= '0;
            disp_q     <= '0;
            div_q      <= '0;
            pos_q      <= '0;
            an_q       <= 6'h3F;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            field_q    <= field_d;
            snap_min_q <= snap_min_d;
            snap_sec_q <= snap_sec_d;
            shadow_q   <= shadow_d;
            disp_q     <= disp_d;
            div_q      <= div_d;
            pos_q      <= pos_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign an_o  = an_q;
    assign seg_o = seg_q;
    assign dp_o  = dp_q;
endmodule
